// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared FIFO pointer-width helper and flag bundle
package uart_fifo_pkg;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_flags_t;

    // One extra pointer bit distinguishes full from empty on wrap.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock byte FIFO with count, thresholds, FWFT option and sticky errors
module uart_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ptr_width(DEPTH);

    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [PTR_W-1:0]      count_w;
    fifo_flags_t           flags;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign count_w = wr_ptr_q - rd_ptr_q;

    always_comb begin
        flags              = '0;
        flags.full         = (count_w == DEPTH_C);
        flags.almost_full  = (count_w >= AFULL_C);
        flags.empty        = (count_w == '0);
        flags.almost_empty = (count_w <= AEMPTY_C);
    end

    // Accept decisions use the flags registered at the start of the cycle.
    assign wr_acc = wr_en & ~flags.full;
    assign rd_acc = rd_en & ~flags.empty;
    assign mem_we = wr_acc & ~flush & ~reset;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && flags.full) begin
                overflow_d = 1'b1;
            end
            if (rd_en && flags.empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
                if (!flush && rd_acc) begin
                    rd_data_d  = ram_rdata;
                    rd_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head word is presented combinationally; zero while empty keeps reset value clean.
            assign rd_data  = flags.empty ? '0 : ram_rdata;
            assign rd_valid = ~flags.empty;
        end
    endgenerate

    assign full         = flags.full;
    assign almost_full  = flags.almost_full;
    assign empty        = flags.empty;
    assign almost_empty = flags.almost_empty;
    assign count        = count_w;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
